irrigation_sequencer: RTL and testbench
=======================================

Name: irrigation_sequencer

Overview:
- Clocked controller for the irrigation datapath: tank level sensors (H/M/L), soil moisture (Us wet, Ua moist), temperature (T), drip valve Vs, sprinkler Bs, inlet valve Ve, alarm and 3-bar level display.
- Synchronises and debounces sensors, sequences fill and irrigation with minimum on-time and a dead-time interlock between Vs and Bs, and latches faults until cleared.
- Top-level of the irrigation controller; drives valve drivers and the 7-seg bars directly.

Parameters:
- DEBOUNCE_CYC, 16: consecutive stable cycles before a sensor vector is accepted (≥2).
- MIN_ON_CYC, 1024: minimum cycles Vs or Bs stays on once opened.
- DEAD_CYC, 8: cycles with Vs=Bs=0 between any valve handover.
- FILL_TIMEOUT_CYC, 65536: maximum continuous Ve-on cycles before fault (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- lvl_h, lvl_m, lvl_l  in  1 each  tank level probes, 1 = water present
- soil_us  in  1  soil saturated
- soil_ua  in  1  soil moist
- temp_hi  in  1  high temperature
- fault_clr  in  1  single-cycle pulse, clears a latched fault
- vs  out  1  drip valve
- bs  out  1  sprinkler valve
- ve  out  1  tank inlet valve
- al  out  1  alarm
- err  out  1  latched fault flag
- state_o  out  3  FSM state encoding
- seg_a, seg_g, seg_d  out  1 each  level bars, active-low (full / medium / low)

Behaviour:
- Reset: vs=bs=ve=al=err=0; seg_*=1 (off); state_o=IDLE; all counters 0; debounced vector marked invalid.
- Inputs pass a 2-flop synchroniser. The 6-bit vector {h,m,l,us,ua,t} is accepted when held for DEBOUNCE_CYC consecutive cycles.
- Latency: input edge to registered output is exactly DEBOUNCE_CYC+3 cycles.
- Until the first vector is accepted, the FSM stays in IDLE and all outputs hold their reset values.
- Level decode: 111=FULL, 011=MED, 001=LOW, 000=EMPTY. Any other code = INVALID.
- Fill control, independent of the FSM:
  - ve sets when level is LOW or EMPTY.
  - ve clears at FULL.
  - Hysteresis: MED keeps ve at its previous value.
  - ve is forced to 0 in FAULT.
- Demand decode:
  - Us=1: NONE.
  - Us=0, Ua=0: SPRAY if level ≥ MED, else DRIP if LOW.
  - Us=0, Ua=1, T=1: DRIP.
  - Us=0, Ua=1, T=0: SPRAY if MED, DRIP otherwise.
  - EMPTY always gives NONE.
- FSM states: IDLE(0), DRIP(1), SPRAY(2), DEAD(3), FAULT(4).
  - IDLE→DRIP/SPRAY when demand≠NONE.
  - In DRIP/SPRAY, after MIN_ON_CYC: on demand=NONE go to IDLE; on the other mode go to DEAD, with the target remembered.
  - DEAD: both valves off for DEAD_CYC cycles, then enter the remembered target if demand still equals it, else IDLE.
  - Any state→FAULT immediately on INVALID level (overrides min-on).
  - EMPTY during DRIP/SPRAY: close at once, go to IDLE (overrides min-on).
  - FAULT→IDLE only on fault_clr while level is valid. fault_clr during an INVALID level is ignored.
- Interlock invariant: vs&bs never 1 in the same cycle, including reset release and fault entry.
- al = err | (level==LOW) | (level==EMPTY). err=1 exactly while in FAULT.
- Display bars (active-low, blank in FAULT):
  - seg_d = ~(l)
  - seg_g = ~(l&m)
  - seg_a = ~(l&m&h)
- Reset asserted mid-operation closes all valves asynchronously.

Optional Feature:
- IRRIG_FILL_TIMEOUT_EN defined: a counter runs while ve=1 and resets when ve=0. Reaching FILL_TIMEOUT_CYC forces FAULT (dry well / stuck probe).
- IRRIG_FILL_TIMEOUT_EN undefined: no counter; ve may stay on indefinitely and FILL_TIMEOUT_CYC is unused.

Decomposition:
- Package irrig_pkg holds:
  - level_e (FULL, MED, LOW, EMPTY, INVALID)
  - demand_e (NONE, DRIP, SPRAY)
  - state_e with fixed 3-bit encodings
  - level-decode function
- One sub-module, irrig_debounce: synchroniser plus stable-count on a width-parameterised vector, with a valid flag.

Test Plan:
- Reset release, level 001, us=ua=0, DEBOUNCE_CYC=4 → ve=1 and al=1 at cycle 7; vs=1 (DRIP); seg_d=0, seg_g=seg_a=1.
- Level 011, dry soil → bs=1. At cycle 10 set us=1 with MIN_ON_CYC=32 → bs stays 1 until 32 on-cycles, then IDLE.
- SPRAY active past min-on, level drops to LOW → bs=0, exactly DEAD_CYC cycles with vs=bs=0, then vs=1. The interlock assertion never fires.
- Level 101 glitch shorter than DEBOUNCE_CYC → no change. Held longer → FAULT: err=1, al=1, vs=bs=ve=0, segs blank.
  - fault_clr while still 101 → ignored.
  - Restore 111, then fault_clr → IDLE.
- With IRRIG_FILL_TIMEOUT_EN and FILL_TIMEOUT_CYC=100, hold level 001 → FAULT at ve-on cycle 100. Without the macro → ve stays 1 for 1000 cycles.
- Assert rst_n=0 mid-DRIP → vs falls in the same cycle, asynchronously; outputs return to reset values.

Source files
------------

// File: rtl/irrig_pkg.sv
// rtl/irrig_pkg.sv - shared types and level decode for the irrigation sequencer
package irrig_pkg;

    typedef enum logic [2:0] {
        LVL_FULL,
        LVL_MED,
        LVL_LOW,
        LVL_EMPTY,
        LVL_INVALID
    } level_e;

    typedef enum logic [1:0] {
        DEM_NONE,
        DEM_DRIP,
        DEM_SPRAY
    } demand_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIP  = 3'd1,
        ST_SPRAY = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Probes fill bottom-up, so only contiguous codes from the bottom are legal.
    function automatic level_e decode_level(input logic [2:0] hml);
        case (hml)
            3'b111:  return LVL_FULL;
            3'b011:  return LVL_MED;
            3'b001:  return LVL_LOW;
            3'b000:  return LVL_EMPTY;
            default: return LVL_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/irrigation_sequencer_debounce.sv
// rtl/irrigation_sequencer_debounce.sv - irrig_debounce: 2-flop sync plus stable-count acceptance
module irrig_debounce #(
    parameter int W          = 6,
    parameter int STABLE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    localparam int CW = $clog2(STABLE_CYC + 1);

    logic [W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [W-1:0]  cand_q, cand_d, stable_q, stable_d;
    logic [1:0]    prime_q, prime_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;

    // Candidate tracking: a vector is accepted on its STABLE_CYC-th identical sample.
    // prime_q keeps the reset contents of the sync chain from being counted.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        prime_d  = {prime_q[0], 1'b1};
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        valid_d  = valid_q;
        if (prime_q[1]) begin
            if (cnt_q == '0 || sync2_q != cand_q) begin
                cand_d = sync2_q;
                cnt_d  = CW'(1);
            end else if (cnt_q < CW'(STABLE_CYC)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == CW'(STABLE_CYC - 1) && sync2_q == cand_q) begin
                stable_d = cand_q;
                valid_d  = 1'b1;
            end
        end
    end

    // Register stage for synchroniser, counter and accepted vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prime_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prime_q  <= prime_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            valid_q  <= valid_d;
        end
    end

    assign dout  = stable_q;
    assign valid = valid_q;

endmodule

// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - irrigation controller top; IRRIG_FILL_TIMEOUT_EN enables the inlet fill timeout
module irrigation_sequencer #(
    parameter int DEBOUNCE_CYC     = 16,
    parameter int MIN_ON_CYC       = 1024,
    parameter int DEAD_CYC         = 8,
    parameter int FILL_TIMEOUT_CYC = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lvl_h,
    input  logic       lvl_m,
    input  logic       lvl_l,
    input  logic       soil_us,
    input  logic       soil_ua,
    input  logic       temp_hi,
    input  logic       fault_clr,
    output logic       vs,
    output logic       bs,
    output logic       ve,
    output logic       al,
    output logic       err,
    output logic [2:0] state_o,
    output logic       seg_a,
    output logic       seg_g,
    output logic       seg_d
);
    import irrig_pkg::*;

    localparam int OW = $clog2(MIN_ON_CYC + 1);
    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [OW-1:0] ON_MAX   = OW'(MIN_ON_CYC);
    localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_CYC);
    localparam logic [DW-1:0] GAP_MAX  = DW'(DEAD_CYC - 1);

    logic [5:0] sens;
    logic       sens_valid;
    level_e     level;
    demand_e    demand;
    logic       fill_timeout;

    state_e        state_q, state_d;
    demand_e       target_q, target_d, last_q, last_d;
    logic [OW-1:0] on_cnt_q, on_cnt_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d, gap_q, gap_d;
    logic vs_q, vs_d, bs_q, bs_d, ve_q, ve_d, al_q, al_d, err_q, err_d;
    logic seg_a_q, seg_a_d, seg_g_q, seg_g_d, seg_d_q, seg_d_d;

    irrig_debounce #(.W(6), .STABLE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({lvl_h, lvl_m, lvl_l, soil_us, soil_ua, temp_hi}),
        .dout  (sens),
        .valid (sens_valid)
    );

    assign level = decode_level(sens[5:3]);

    // Demand from debounced soil/temperature/level: sens = {h,m,l,us,ua,t}.
    always_comb begin
        demand = DEM_NONE;
        if (!sens[2] && level != LVL_EMPTY && level != LVL_INVALID) begin
            if (!sens[1])
                demand = (level == LVL_LOW) ? DEM_DRIP : DEM_SPRAY;
            else if (sens[0])
                demand = DEM_DRIP;
            else
                demand = (level == LVL_MED) ? DEM_SPRAY : DEM_DRIP;
        end
    end

`ifdef IRRIG_FILL_TIMEOUT_EN
    localparam int FW = $clog2(FILL_TIMEOUT_CYC + 1);
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;

    // Counts consecutive inlet-on cycles; the last allowed one raises the fault.
    always_comb begin
        fill_cnt_d   = ve_q ? fill_cnt_q + 1'b1 : '0;
        fill_timeout = ve_q && (fill_cnt_q == FW'(FILL_TIMEOUT_CYC - 1));
    end

    // Fill-duration counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_cnt_q <= '0;
        else        fill_cnt_q <= fill_cnt_d;
    end
`else
    // Timeout compiled out; the comparison is never true for a legal limit.
    assign fill_timeout = (FILL_TIMEOUT_CYC <= 0);
`endif

    // Valve sequencing: min-on hold, dead-time handover, fault latch.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (sens_valid) begin
            case (state_q)
                ST_IDLE: begin
                    // Opening the other valve straight from IDLE still honours the dead time.
                    if (demand != DEM_NONE &&
                        (last_q == DEM_NONE || last_q == demand || gap_q >= GAP_MAX))
                        state_d = (demand == DEM_DRIP) ? ST_DRIP : ST_SPRAY;
                end
                ST_DRIP, ST_SPRAY: begin
                    if (level == LVL_EMPTY) begin
                        state_d = ST_IDLE;
                    end else if (on_cnt_q >= ON_MAX) begin
                        if (demand == DEM_NONE) begin
                            state_d = ST_IDLE;
                        end else if (demand != ((state_q == ST_DRIP) ? DEM_DRIP : DEM_SPRAY)) begin
                            state_d  = ST_DEAD;
                            target_d = demand;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_q >= DEAD_MAX) begin
                        if (demand == target_q)
                            state_d = (target_q == DEM_DRIP) ? ST_DRIP : ST_SPRAY;
                        else
                            state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && level != LVL_INVALID) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (level == LVL_INVALID || fill_timeout) state_d = ST_FAULT;
        end
    end

    // Counters and registered outputs, all derived from the next state.
    always_comb begin
        on_cnt_d   = '0;
        dead_cnt_d = '0;
        gap_d      = gap_q;
        last_d     = last_q;
        if (state_d == ST_DRIP || state_d == ST_SPRAY) begin
            on_cnt_d = (state_d != state_q) ? OW'(1) :
                       (on_cnt_q < ON_MAX) ? on_cnt_q + 1'b1 : on_cnt_q;
            last_d   = (state_d == ST_DRIP) ? DEM_DRIP : DEM_SPRAY;
            gap_d    = '0;
        end else if (gap_q < GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end
        if (state_d == ST_DEAD)
            dead_cnt_d = (state_q == ST_DEAD) ? dead_cnt_q + 1'b1 : DW'(1);

        vs_d    = (state_d == ST_DRIP);
        bs_d    = (state_d == ST_SPRAY);
        err_d   = (state_d == ST_FAULT);
        ve_d    = ve_q;
        al_d    = 1'b0;
        seg_a_d = 1'b1;
        seg_g_d = 1'b1;
        seg_d_d = 1'b1;
        if (sens_valid) begin
            if (state_d == ST_FAULT)                          ve_d = 1'b0;
            else if (level == LVL_LOW || level == LVL_EMPTY)  ve_d = 1'b1;
            else if (level == LVL_FULL)                       ve_d = 1'b0;
            al_d = err_d || level == LVL_LOW || level == LVL_EMPTY;
            if (state_d != ST_FAULT) begin
                seg_d_d = ~sens[3];
                seg_g_d = ~(sens[3] & sens[4]);
                seg_a_d = ~(sens[3] & sens[4] & sens[5]);
            end
        end
    end

    // State, counters and output registers; reset closes every valve immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            target_q   <= DEM_NONE;
            last_q     <= DEM_NONE;
            on_cnt_q   <= '0;
            dead_cnt_q <= '0;
            gap_q      <= '0;
            vs_q       <= 1'b0;
            bs_q       <= 1'b0;
            ve_q       <= 1'b0;
            al_q       <= 1'b0;
            err_q      <= 1'b0;
            seg_a_q    <= 1'b1;
            seg_g_q    <= 1'b1;
            seg_d_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            last_q     <= last_d;
            on_cnt_q   <= on_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            gap_q      <= gap_d;
            vs_q       <= vs_d;
            bs_q       <= bs_d;
            ve_q       <= ve_d;
            al_q       <= al_d;
            err_q      <= err_d;
            seg_a_q    <= seg_a_d;
            seg_g_q    <= seg_g_d;
            seg_d_q    <= seg_d_d;
        end
    end

    assign vs      = vs_q;
    assign bs      = bs_q;
    assign ve      = ve_q;
    assign al      = al_q;
    assign err     = err_q;
    assign state_o = state_q;
    assign seg_a   = seg_a_q;
    assign seg_g   = seg_g_q;
    assign seg_d   = seg_d_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb/tb_irrigation_sequencer.sv - directed, table-driven bench for irrigation_sequencer
module tb_irrigation_sequencer;

    localparam int DEB  = 4;
    localparam int MINON = 32;
    localparam int DEAD = 8;

    // {vs,bs,ve,al,err,state[2:0],seg_a,seg_g,seg_d}
    localparam logic [10:0] RST_P = 11'b00000_000_111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lvl_h = 1'b0, lvl_m = 1'b0, lvl_l = 1'b0;
    logic soil_us = 1'b0, soil_ua = 1'b0, temp_hi = 1'b0, fault_clr = 1'b0;
    logic vs, bs, ve, al, err, seg_a, seg_g, seg_d;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    irrigation_sequencer #(
        .DEBOUNCE_CYC(DEB), .MIN_ON_CYC(MINON), .DEAD_CYC(DEAD), .FILL_TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l),
        .soil_us(soil_us), .soil_ua(soil_ua), .temp_hi(temp_hi),
        .fault_clr(fault_clr),
        .vs(vs), .bs(bs), .ve(ve), .al(al), .err(err), .state_o(state_o),
        .seg_a(seg_a), .seg_g(seg_g), .seg_d(seg_d)
    );

    always #5 clk = ~clk;

    // Interlock: both valves must never be open together.
    always @(negedge clk) begin
        checks++;
        if (vs && bs) begin
            errors++;
            $display("FAIL interlock vs=%0b bs=%0b at %0t", vs, bs, $time);
        end
    end

    typedef struct {
        logic [2:0]  lvl;
        logic        us, ua, t;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [10:0] outs();
        return {vs, bs, ve, al, err, state_o, seg_a, seg_g, seg_d};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] lvl, input logic us, input logic ua, input logic t);
        {lvl_h, lvl_m, lvl_l} = lvl;
        soil_us = us;
        soil_ua = ua;
        temp_hi = t;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with inputs already applied; returns 1 time unit after the release point.
    task automatic start(input logic [2:0] lvl, input logic us, input logic ua, input logic t);
        rst_n = 1'b0;
        fault_clr = 1'b0;
        set_in(lvl, us, ua, t);
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int g;
        vecs[0]  = '{3'b001, 1'b0, 1'b0, 1'b0, 11'b10110_001_110};
        vecs[1]  = '{3'b011, 1'b0, 1'b0, 1'b0, 11'b01000_010_100};
        vecs[2]  = '{3'b111, 1'b0, 1'b0, 1'b0, 11'b01000_010_000};
        vecs[3]  = '{3'b111, 1'b0, 1'b1, 1'b1, 11'b10000_001_000};
        vecs[4]  = '{3'b111, 1'b0, 1'b1, 1'b0, 11'b10000_001_000};
        vecs[5]  = '{3'b011, 1'b0, 1'b1, 1'b0, 11'b01000_010_100};
        vecs[6]  = '{3'b011, 1'b0, 1'b1, 1'b1, 11'b10000_001_100};
        vecs[7]  = '{3'b001, 1'b0, 1'b1, 1'b0, 11'b10110_001_110};
        vecs[8]  = '{3'b000, 1'b0, 1'b0, 1'b0, 11'b00110_000_111};
        vecs[9]  = '{3'b111, 1'b1, 1'b0, 1'b0, 11'b00000_000_000};
        vecs[10] = '{3'b101, 1'b0, 1'b0, 1'b0, 11'b00011_100_111};
        vecs[11] = '{3'b010, 1'b0, 1'b0, 1'b0, 11'b00011_100_111};
        vecs[12] = '{3'b001, 1'b1, 1'b1, 1'b1, 11'b00110_000_110};

        // Reset values while held in reset.
        cyc(1);
        check("reset_state", 32'(outs()), 32'(RST_P));

        // First accepted vector: outputs unchanged at DEB+2, decoded at DEB+3.
        for (int i = 0; i < 13; i++) begin
            start(vecs[i].lvl, vecs[i].us, vecs[i].ua, vecs[i].t);
            cyc(DEB + 2);
            check($sformatf("vec%0d_pre", i), 32'(outs()), 32'(RST_P));
            cyc(1);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // SPRAY held for exactly MINON on-cycles after demand drops.
        start(3'b011, 1'b0, 1'b0, 1'b0);
        cyc(DEB + 3);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 3) soil_us = 1'b1;
            if (bs) n++;
            else break;
            cyc(1);
        end
        check("minon_cycles", 32'(n), 32'(MINON));
        check("minon_idle", 32'(state_o), 32'd0);

        // SPRAY -> DRIP handover through DEAD.
        start(3'b011, 1'b0, 1'b0, 1'b0);
        cyc(DEB + 3 + 40);
        set_in(3'b001, 1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bs) n++;
            else break;
        end
        check("handover_latency", 32'(n), 32'(DEB + 2));
        check("dead_state", 32'(state_o), 32'd3);
        g = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (!vs && !bs) g++;
            else break;
        end
        check("dead_cycles", 32'(g), 32'(DEAD));
        check("dead_to_drip", 32'(outs()), 32'(11'b10110_001_110));

        // EMPTY closes DRIP before min-on expires.
        start(3'b001, 1'b0, 1'b0, 1'b0);
        cyc(DEB + 5);
        set_in(3'b000, 1'b0, 1'b0, 1'b0);
        cyc(DEB + 2);
        check("empty_pre", 32'(outs()), 32'(11'b10110_001_110));
        cyc(1);
        check("empty_idle", 32'(outs()), 32'(11'b00110_000_111));

        // Glitch of DEB-1 cycles is rejected, then a held invalid code faults.
        start(3'b111, 1'b1, 1'b0, 1'b0);
        cyc(DEB + 3);
        check("full_idle", 32'(outs()), 32'(11'b00000_000_000));
        set_in(3'b101, 1'b1, 1'b0, 1'b0);
        cyc(DEB - 1);
        set_in(3'b111, 1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            if (state_o != 3'd0 || err) n++;
        end
        check("glitch_ignored", 32'(n), 32'd0);
        set_in(3'b101, 1'b1, 1'b0, 1'b0);
        cyc(DEB + 2);
        check("fault_pre", 32'(outs()), 32'(11'b00000_000_000));
        cyc(1);
        check("fault_entry", 32'(outs()), 32'(11'b00011_100_111));
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        cyc(3);
        check("clr_ignored", 32'(outs()), 32'(11'b00011_100_111));
        set_in(3'b111, 1'b1, 1'b0, 1'b0);
        cyc(DEB + 3);
        check("fault_latched", 32'(outs()), 32'(11'b00011_100_111));
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        check("fault_cleared", 32'(outs()), 32'(11'b00000_000_000));

        // Without the timeout option the inlet may stay open indefinitely.
        start(3'b001, 1'b1, 1'b0, 1'b0);
        cyc(DEB + 3);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ve && state_o == 3'd0) n++;
            cyc(1);
        end
        check("ve_no_timeout", 32'(n), 32'd1000);

        // Asynchronous reset mid-DRIP, away from any clock edge.
        start(3'b001, 1'b0, 1'b0, 1'b0);
        cyc(DEB + 6);
        check("drip_before_rst", 32'(outs()), 32'(11'b10110_001_110));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'(RST_P));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
